// File: rtl/snake_food_gen_if.sv
// Purpose: groups the request, occupancy-query and food-result signals of snake_food_gen.
// Ports: i_Req/i_Head/i_QueryHit flow into the generator; o_QueryEn/o_QueryAddr/o_FoodLocation/
//        o_Valid/o_Busy/o_Full flow out. master = game/bench side, slave = generator side.
interface snake_food_gen_if #(
  parameter int c_GRID_IDX_SZ = 10
) ();
  logic                     i_Req;
  logic [c_GRID_IDX_SZ-1:0] i_Head;
  logic                     i_QueryHit;
  logic                     o_QueryEn;
  logic [c_GRID_IDX_SZ-1:0] o_QueryAddr;
  logic [c_GRID_IDX_SZ-1:0] o_FoodLocation;
  logic                     o_Valid;
  logic                     o_Busy;
  logic                     o_Full;

  modport master (
    output i_Req, i_Head, i_QueryHit,
    input  o_QueryEn, o_QueryAddr, o_FoodLocation, o_Valid, o_Busy, o_Full
  );

  modport slave (
    input  i_Req, i_Head, i_QueryHit,
    output o_QueryEn, o_QueryAddr, o_FoodLocation, o_Valid, o_Busy, o_Full
  );
endinterface

// File: rtl/snake_food_gen.sv
// Purpose: picks a free interior grid cell for the snake's food from a free-running LFSR,
//          rejecting border cells and the head, and confirming each candidate against the
//          occupancy grid through a one-cycle-latency query port.
// Ports: i_Clk, i_Rst (async, active high); io_Bus (slave) carries i_Req, i_Head, i_QueryHit,
//        o_QueryEn, o_QueryAddr, o_FoodLocation, o_Valid, o_Busy, o_Full.
// Build option: define SNAKE_FOOD_SCAN_EN to add the raster-scan fallback and o_Full reporting.
module snake_food_gen #(
  parameter int          c_GRID_IDX_SZ = 10,
  parameter int          c_COL_BITS    = 5,
  parameter int          c_ROW_BITS    = 5,
  parameter logic [15:0] c_SEED        = 16'hACE1,  // must be nonzero or the LFSR locks up
  parameter int          c_MAX_TRIES   = 15,
  parameter int          c_INIT_FOOD   = 264
) (
  input logic              i_Clk,
  input logic              i_Rst,
  snake_food_gen_if.slave  io_Bus
);
  // With power-of-two dimensions the border columns/rows are all-zeros and all-ones.
  localparam logic [c_COL_BITS-1:0] c_COL_FIRST = c_COL_BITS'(1);
  localparam logic [c_COL_BITS-1:0] c_COL_LAST  = {{(c_COL_BITS-1){1'b1}}, 1'b0};
  localparam logic [c_ROW_BITS-1:0] c_ROW_FIRST = c_ROW_BITS'(1);
  localparam logic [c_ROW_BITS-1:0] c_ROW_LAST  = {{(c_ROW_BITS-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {S_IDLE, S_DRAW, S_QUERY, S_WAIT, S_DONE, S_SCAN} state_t;

  state_t                   r_State, w_NextState;
  logic [15:0]              r_Lfsr;
  logic [c_GRID_IDX_SZ-1:0] r_Cand, r_QueryAddr, r_FoodLocation, w_DrawCand;
  logic [c_COL_BITS-1:0]    w_DrawCol;
  logic [c_ROW_BITS-1:0]    w_DrawRow;
  logic                     w_DrawReject, w_Hit, w_ToScan, w_InScan, w_ScanLast;

  // Galois LFSR, free-running in every state so draw timing adds entropy.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) r_Lfsr <= c_SEED;
    else       r_Lfsr <= (r_Lfsr >> 1) ^ (r_Lfsr[0] ? 16'hB400 : 16'h0000);
  end

  assign w_DrawCol    = r_Lfsr[c_COL_BITS-1:0];
  assign w_DrawRow    = r_Lfsr[c_COL_BITS +: c_ROW_BITS];
  assign w_DrawCand   = c_GRID_IDX_SZ'({w_DrawRow, w_DrawCol});
  assign w_DrawReject = (w_DrawCol == '0) || (w_DrawCol == '1) ||
                        (w_DrawRow == '0) || (w_DrawRow == '1) ||
                        (w_DrawCand == io_Bus.i_Head);

`ifdef SNAKE_FOOD_SCAN_EN
  localparam int                    c_TRY_BITS = $clog2(c_MAX_TRIES + 1);
  localparam logic [c_TRY_BITS-1:0] c_TRY_MAX  = c_TRY_BITS'(c_MAX_TRIES);

  logic [c_TRY_BITS-1:0]    r_Tries, w_TriesInc;
  logic [c_GRID_IDX_SZ-1:0] r_ScanIdx, w_ScanNext;
  logic [c_COL_BITS-1:0]    w_ScanCol;
  logic [c_ROW_BITS-1:0]    w_ScanRow, w_ScanRowInc;
  logic                     r_Full;

  assign w_TriesInc   = (r_Tries == c_TRY_MAX) ? c_TRY_MAX : r_Tries + 1'b1;
  // The rejection that saturates the counter diverts to the scan instead of another draw.
  assign w_ToScan     = (w_TriesInc == c_TRY_MAX);
  // A saturated counter can only be seen in WAIT once scanning has started.
  assign w_InScan     = (r_Tries == c_TRY_MAX);
  assign w_ScanCol    = r_ScanIdx[c_COL_BITS-1:0];
  assign w_ScanRow    = r_ScanIdx[c_COL_BITS +: c_ROW_BITS];
  assign w_ScanRowInc = w_ScanRow + 1'b1;
  assign w_ScanLast   = (w_ScanCol == c_COL_LAST) && (w_ScanRow == c_ROW_LAST);
  // While scanning, the head is not excluded up front, so it is folded into the hit.
  assign w_Hit        = io_Bus.i_QueryHit || (w_InScan && (r_Cand == io_Bus.i_Head));

  // Index 0 marks "scan not started"; the first scan cell is (1,1).
  always_comb begin
    w_ScanNext = r_ScanIdx;
    if (r_ScanIdx == '0)
      w_ScanNext = c_GRID_IDX_SZ'({c_ROW_FIRST, c_COL_FIRST});
    else if (w_ScanCol == c_COL_LAST)
      w_ScanNext = c_GRID_IDX_SZ'({w_ScanRowInc, c_COL_FIRST});
    else
      w_ScanNext = c_GRID_IDX_SZ'({w_ScanRow, w_ScanCol + 1'b1});
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_Tries   <= '0;
      r_ScanIdx <= '0;
      r_Full    <= 1'b0;
    end else begin
      r_Full <= (r_State == S_WAIT) && w_Hit && w_InScan && w_ScanLast;
      case (r_State)
        S_IDLE: if (io_Bus.i_Req) begin
          r_Tries   <= '0;
          r_ScanIdx <= '0;
        end
        S_DRAW: if (w_DrawReject) r_Tries <= w_TriesInc;
        S_WAIT: if (w_Hit)        r_Tries <= w_TriesInc;
        S_SCAN: r_ScanIdx <= w_ScanNext;
        default: ;
      endcase
    end
  end

  assign io_Bus.o_Full = r_Full;
`else
  assign w_ToScan      = 1'b0;
  assign w_InScan      = 1'b0;
  assign w_ScanLast    = 1'b0;
  assign w_Hit         = io_Bus.i_QueryHit;
  assign io_Bus.o_Full = 1'b0;
`endif

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) r_State <= S_IDLE;
    else       r_State <= w_NextState;
  end

  always_comb begin
    w_NextState = r_State;
    case (r_State)
      S_IDLE:  if (io_Bus.i_Req) w_NextState = S_DRAW;
      S_DRAW:  if (w_DrawReject) w_NextState = w_ToScan ? S_SCAN : S_DRAW;
               else              w_NextState = S_QUERY;
      S_QUERY: w_NextState = S_WAIT;
      S_WAIT:  begin
        if (!w_Hit)                      w_NextState = S_DONE;
        else if (w_InScan && w_ScanLast) w_NextState = S_IDLE;
        else if (w_ToScan)               w_NextState = S_SCAN;
        else                             w_NextState = S_DRAW;
      end
      S_DONE:  w_NextState = S_IDLE;
      S_SCAN:  w_NextState = S_QUERY;
      default: w_NextState = S_IDLE;
    endcase
  end

  // Query address is loaded only on entry to QUERY, so it holds between lookups.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_Cand         <= '0;
      r_QueryAddr    <= '0;
      r_FoodLocation <= c_GRID_IDX_SZ'(c_INIT_FOOD);
    end else begin
      case (r_State)
        S_DRAW: begin
          r_Cand <= w_DrawCand;
          if (!w_DrawReject) r_QueryAddr <= w_DrawCand;
        end
        S_WAIT: if (!w_Hit) r_FoodLocation <= r_Cand;
`ifdef SNAKE_FOOD_SCAN_EN
        S_SCAN: begin
          r_Cand      <= w_ScanNext;
          r_QueryAddr <= w_ScanNext;
        end
`endif
        default: ;
      endcase
    end
  end

  assign io_Bus.o_QueryEn      = (r_State == S_QUERY);
  assign io_Bus.o_QueryAddr    = r_QueryAddr;
  assign io_Bus.o_FoodLocation = r_FoodLocation;
  assign io_Bus.o_Valid        = (r_State == S_DONE);
  assign io_Bus.o_Busy         = (r_State != S_IDLE);
endmodule

// File: tb/tb_snake_food_gen.sv
module tb_snake_food_gen;
  logic i_Clk;
  logic i_Rst;
  snake_food_gen_if bus ();

  snake_food_gen dut (
    .i_Clk  (i_Clk),
    .i_Rst  (i_Rst),
    .io_Bus (bus)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  int n_checks = 0;
  int n_fail   = 0;
  int hit_mode = 0;   // 0: never hit, 1: always hit, 2: hit everywhere except 500
  int qcount   = 0;
  int vcount   = 0;
  int fcount   = 0;
  int qlog[$];
  logic [15:0] m_lfsr;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Reference LFSR, free-running from the seed like the generator's.
  always @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) m_lfsr <= 16'hACE1;
    else       m_lfsr <= lfsr_next(m_lfsr);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic hit_for(input int addr);
    case (hit_mode)
      0:       return 1'b0;
      1:       return 1'b1;
      default: return (addr != 500);
    endcase
  endfunction

  // Walk the LFSR from the value the first DRAW will see; returns first accepted cell.
  task automatic predict(input logic [15:0] l, input int head, output int cand, output int rej);
    int col, row;
    rej = 0;
    cand = -1;
    for (int i = 0; i < 1000; i++) begin
      col = int'(l[4:0]);
      row = int'(l[9:5]);
      if (col >= 1 && col <= 30 && row >= 1 && row <= 30 && (row*32 + col) != head) begin
        cand = row*32 + col;
        break;
      end
      rej++;
      l = lfsr_next(l);
    end
  endtask

  task automatic tick();
    @(posedge i_Clk);
    #1;
    if (bus.o_QueryEn) begin
      qcount++;
      qlog.push_back(int'(bus.o_QueryAddr));
      bus.i_QueryHit = hit_for(int'(bus.o_QueryAddr));
    end
    if (bus.o_Valid) vcount++;
    if (bus.o_Full)  fcount++;
  endtask

  task automatic do_req();
    bus.i_Req = 1'b1;
    tick();
    bus.i_Req = 1'b0;
  endtask

  task automatic wait_valid(input int bound, output int cycles);
    int v0 = vcount;
    cycles = 0;
    while (vcount == v0 && cycles < bound) begin
      tick();
      cycles++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_food"},  32'(bus.o_FoodLocation), 264);
    chk({tag, "_valid"}, 32'(bus.o_Valid), 0);
    chk({tag, "_busy"},  32'(bus.o_Busy), 0);
    chk({tag, "_qen"},   32'(bus.o_QueryEn), 0);
    chk({tag, "_qaddr"}, 32'(bus.o_QueryAddr), 0);
    chk({tag, "_full"},  32'(bus.o_Full), 0);
  endtask

  initial begin
    int exp_c, exp_k, exp_c2, exp_k2, cyc, q0, v0, f0, n500, bad, idx;
    logic [15:0] l;
    i_Rst = 1'b1;
    bus.i_Req = 1'b0;
    bus.i_Head = '0;
    bus.i_QueryHit = 1'b0;

    // Reset state, held and just after release.
    repeat (3) @(posedge i_Clk);
    #1;
    check_reset_outputs("rst_hold");
    i_Rst = 1'b0;
    tick();
    check_reset_outputs("rst_rel");

    // Basic placement, no occupancy hits, head on the border.
    hit_mode = 0;
    q0 = qcount;
    do_req();
    chk("busy_rise", 32'(bus.o_Busy), 1);
    l = m_lfsr;
    predict(l, 0, exp_c, exp_k);
    wait_valid(200, cyc);
    chk("lat1", cyc, 3 + exp_k);
    chk("food1", 32'(bus.o_FoodLocation), exp_c);
    chk("food1_col_ok", 32'(bus.o_FoodLocation[4:0] >= 1 && bus.o_FoodLocation[4:0] <= 30), 1);
    chk("food1_row_ok", 32'(bus.o_FoodLocation[9:5] >= 1 && bus.o_FoodLocation[9:5] <= 30), 1);
    chk("q1_count", qcount - q0, 1);
    tick();
    chk("busy_fall", 32'(bus.o_Busy), 0);

    // Head sitting on the first interior candidate forces one more draw.
    tick();
    do_req();
    l = m_lfsr;
    predict(l, 0, exp_c, exp_k);
    bus.i_Head = 10'(exp_c);
    predict(l, exp_c, exp_c2, exp_k2);
    wait_valid(200, cyc);
    chk("lat_head", cyc, 3 + exp_k2);
    chk("food_head", 32'(bus.o_FoodLocation), exp_c2);
    chk("food_not_head", 32'(bus.o_FoodLocation != 10'(exp_c)), 1);
    bus.i_Head = '0;
    tick();

    // A request during the second busy cycle is dropped.
    v0 = vcount;
    do_req();
    tick();
    bus.i_Req = 1'b1;
    tick();
    bus.i_Req = 1'b0;
    repeat (60) tick();
    chk("ignore_req_valids", vcount - v0, 1);
    chk("ignore_req_idle", 32'(bus.o_Busy), 0);

    // Reset asserted in QUERY aborts at once.
    do_req();
    cyc = 0;
    while (!bus.o_QueryEn && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("query_seen", 32'(bus.o_QueryEn), 1);
    i_Rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge i_Clk);
    i_Rst = 1'b0;
    v0 = vcount;
    f0 = fcount;
    repeat (20) tick();
    chk("rst_no_valid", vcount - v0, 0);
    chk("rst_no_full", fcount - f0, 0);

`ifdef SNAKE_FOOD_SCAN_EN
    // Everything occupied except cell 500.
    hit_mode = 2;
    qlog.delete();
    do_req();
    wait_valid(6000, cyc);
    chk("scan500_done", 32'(cyc < 6000), 1);
    chk("scan500_food", 32'(bus.o_FoodLocation), 500);
    n500 = 0;
    foreach (qlog[i]) if (qlog[i] == 500) n500++;
    chk("scan500_queries", n500, 1);
    tick();

    // Grid completely full: 900-cell raster scan, then o_Full.
    i_Rst = 1'b1;
    #1;
    @(negedge i_Clk);
    i_Rst = 1'b0;
    hit_mode = 1;
    qlog.delete();
    v0 = vcount;
    f0 = fcount;
    do_req();
    cyc = 0;
    while (bus.o_Busy && cyc < 6000) begin
      tick();
      cyc++;
    end
    chk("full_done", 32'(cyc < 6000), 1);
    chk("full_pulses", fcount - f0, 1);
    chk("full_no_valid", vcount - v0, 0);
    chk("full_food", 32'(bus.o_FoodLocation), 264);
    chk("full_busy", 32'(bus.o_Busy), 0);
    chk("full_qsize_ok", 32'(qlog.size() >= 900 && qlog.size() <= 915), 1);
    if (qlog.size() >= 900) begin
      idx = qlog.size() - 900;
      chk("scan_first", qlog[idx], 33);
      chk("scan_last", qlog[qlog.size() - 1], 990);
      bad = 0;
      for (int r = 1; r <= 30; r++)
        for (int c = 1; c <= 30; c++) begin
          if (qlog[idx] != r*32 + c) bad++;
          idx++;
        end
      chk("scan_raster", bad, 0);
    end
    tick();
    chk("full_pulse_once", fcount - f0, 1);
`else
    // Without the scan fallback a full grid just keeps drawing.
    hit_mode = 1;
    v0 = vcount;
    f0 = fcount;
    do_req();
    repeat (5000) tick();
    chk("nofb_busy", 32'(bus.o_Busy), 1);
    chk("nofb_no_valid", vcount - v0, 0);
    chk("nofb_no_full", fcount - f0, 0);
    hit_mode = 0;
    wait_valid(200, cyc);
    chk("nofb_release", 32'(cyc < 200), 1);
    chk("nofb_food_col", 32'(bus.o_FoodLocation[4:0] >= 1 && bus.o_FoodLocation[4:0] <= 30), 1);
    chk("nofb_food_row", 32'(bus.o_FoodLocation[9:5] >= 1 && bus.o_FoodLocation[9:5] <= 30), 1);
    tick();
    chk("nofb_idle", 32'(bus.o_Busy), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
